na_conf_wb_arbiter: RTL and testbench
=====================================

// Module: na_conf_wb_arbiter
// PURPOSE
//  Round-robin Wishbone B3 arbiter that shares one network-adapter configuration slave port (wbs_*) between
//  NUM_MASTERS requesters, e.g. tile CPU bus and debug processor. Holds the grant for a whole cycle (cyc high,
//  incl. bursts) and aborts stalled accesses with err after a programmable timeout. Sits between bus masters
//  and the NA config slave in the tile.
// PARAMETERS
//  NUM_MASTERS  2    number of requesting masters (>=2)
//  TIMEOUT      255  cycles stb may wait for ack/rty/err before arbiter returns err; 0 disables timeout
// PORTS
//  clk          in   1        tile clock; all logic on rising edge
//  rst          in   1        synchronous, active-low reset (rst==0 resets on the next clk edge)
//  m_adr_i      in   32*N     master addresses, master k at [32k+31:32k]
//  m_dat_i      in   32*N     master write data
//  m_sel_i      in   4*N      byte selects
//  m_cyc_i      in   N        cycle valid per master (request)
//  m_stb_i      in   N        strobe per master
//  m_we_i       in   N        write enable per master
//  m_cti_i      in   3*N      cycle type ids
//  m_bte_i      in   2*N      burst type ext
//  m_dat_o      out  32       read data, shared bus (valid for granted master only)
//  m_ack_o      out  N        ack, routed only to granted master
//  m_rty_o      out  N        retry, routed only to granted master
//  m_err_o      out  N        error (slave err or timeout), granted master only
//  s_adr_o,s_dat_o,s_sel_o,s_cyc_o,s_stb_o,s_we_o,s_cti_o,s_bte_o  out  32,32,4,1,1,1,3,2  to config slave
//  s_dat_i,s_ack_i,s_rty_i,s_err_i  in  32,1,1,1  from config slave
//  grant_o      out  N        one-hot current grant, 0 when idle (debug/status)
// BEHAVIOUR
//  Reset: state IDLE, grant_o=0, last=N-1 (master 0 highest priority first), timeout counter 0;
//   s_cyc_o=s_stb_o=0, all m_ack_o/m_rty_o/m_err_o=0, m_dat_o=0. Reset mid-transfer aborts it: s_cyc_o low
//   from the cycle after rst sampled low; no response delivered to the master.
//  States: IDLE, BUSY, TOERR.
//  IDLE: if any m_cyc_i, grant = first requester scanning last+1, last+2, ... mod N; grant registered ->
//   BUSY. 1-cycle arbitration latency: s_cyc_o rises the cycle after m_cyc_i first sampled high.
//  BUSY: s_* outputs combinationally mirror granted master's signals; s_dat_i -> m_dat_o; s_ack_i/s_rty_i/
//   s_err_i -> bit g of m_ack_o/m_rty_o/m_err_o, other bits 0. Grant held while granted m_cyc_i=1
//   (requests of others ignored, incl. multi-beat bursts). Granted m_cyc_i=0 -> IDLE, last=g, grant_o=0;
//   s_cyc_o low in that same cycle (mirrored). No re-arbitration in the release cycle.
//  Timeout (TIMEOUT>0): counter increments each BUSY cycle with s_stb_o=1 and no ack/rty/err; clears on
//   any response or stb low. Counter==TIMEOUT-1 with still no response -> TOERR.
//  TOERR (1 cycle): s_stb_o forced 0, s_cyc_o held; m_err_o[g]=1 for exactly one cycle; counter cleared;
//   next: BUSY if m_cyc_i[g]=1 else IDLE (last=g). Late slave ack in TOERR is dropped.
//  Simultaneous: slave response in the cycle counter hits TIMEOUT-1 wins (normal response, no TOERR).
//  Counter width $clog2(TIMEOUT+1); saturating, never wraps. last wraps N-1 -> 0.
//  Masters ignore all responses while not granted; a master dropping cyc while not granted is legal.
// STRUCTURE
//  Package na_conf_arb_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, TOERR=2'd2), clog2 function,
//   Wishbone field widths (ADR_W=32, DAT_W=32, SEL_W=4, CTI_W=3, BTE_W=2).
//  Sub-module rr_arbiter (#N): combinational req[N] + last -> one-hot gnt[N]; reused by other NoC arbiters.
//  Top: FSM, timeout counter, grant register, output muxes.
// TESTING
//  1 Reset: rst=0 for 3 clk with m_cyc_i=2'b11 -> s_cyc_o=0, grant_o=0, all m_*_o responses 0.
//  2 Both request at once from reset -> master0 granted (grant_o=01), s_cyc_o high 1 cycle later; after m0
//    drops cyc, master1 granted next arbitration (grant_o=10).
//  3 Master1 4-beat burst (cti=3'b010..3'b111) while m0 requests -> grant stays 10 for all 4 acks, m_ack_o[0]
//    never asserted; m0 granted only after m1 cyc drops.
//  4 TIMEOUT=8, slave never acks -> m_err_o[g]=1 exactly on 9th cycle after s_stb_o rose, s_stb_o=0 that
//    cycle; ack on cycle 8 instead -> m_ack_o only, no err.
//  5 rst pulled low mid-burst of master0 -> next cycle s_cyc_o=0, grant_o=0; after release master0 regains
//    first priority (last=N-1).
//  6 Read 32'hDEADBEEF from slave at adr 16'h0004 via master1 -> m_dat_o=32'hDEADBEEF with m_ack_o=2'b10.

Source files
------------

// File: rtl/na_conf_arb_pkg.sv
// Shared types and constants for the NA configuration-port Wishbone arbiter.
// Also hosts a constant-foldable clog2 used for counter and index widths.
package na_conf_arb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CTI_W = 3;
  localparam int unsigned BTE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_TOERR = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping at N.
// Produces a one-hot grant, all zeros when nobody requests.
module rr_arbiter
  import na_conf_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned LW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = LW'((32'(last_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/na_conf_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing the NA config slave between masters.
// Grant is held for a whole cyc; stalled strobes are aborted with err after TIMEOUT cycles.
module na_conf_wb_arbiter
  import na_conf_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADR_W*NUM_MASTERS-1:0]   m_adr_i,
  input  logic [DAT_W*NUM_MASTERS-1:0]   m_dat_i,
  input  logic [SEL_W*NUM_MASTERS-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]         m_cyc_i,
  input  logic [NUM_MASTERS-1:0]         m_stb_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [CTI_W*NUM_MASTERS-1:0]   m_cti_i,
  input  logic [BTE_W*NUM_MASTERS-1:0]   m_bte_i,
  output logic [DAT_W-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  output logic [NUM_MASTERS-1:0]         m_rty_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic [ADR_W-1:0]               s_adr_o,
  output logic [DAT_W-1:0]               s_dat_o,
  output logic [SEL_W-1:0]               s_sel_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic [CTI_W-1:0]               s_cti_o,
  output logic [BTE_W-1:0]               s_bte_o,
  input  logic [DAT_W-1:0]               s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_rty_i,
  input  logic                           s_err_i,
  output logic [NUM_MASTERS-1:0]         grant_o
);

  localparam int unsigned LW    = clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [LW-1:0]          last_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [LW-1:0]          gidx;
  logic [ADR_W-1:0]       g_adr;
  logic [DAT_W-1:0]       g_dat;
  logic [SEL_W-1:0]       g_sel;
  logic [CTI_W-1:0]       g_cti;
  logic [BTE_W-1:0]       g_bte;
  logic                   g_cyc, g_stb, g_we;
  logic                   resp;

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .LW (LW)
  ) u_rr (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  assign resp    = s_ack_i | s_rty_i | s_err_i;
  assign grant_o = grant_q;

  // Select the granted master's request fields; all zero when nobody holds the grant.
  always_comb begin
    gidx  = '0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        gidx  = LW'(i);
        g_adr = m_adr_i[i*ADR_W +: ADR_W];
        g_dat = m_dat_i[i*DAT_W +: DAT_W];
        g_sel = m_sel_i[i*SEL_W +: SEL_W];
        g_cti = m_cti_i[i*CTI_W +: CTI_W];
        g_bte = m_bte_i[i*BTE_W +: BTE_W];
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
        g_we  = m_we_i[i];
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_rty_o = '0;
    m_err_o = '0;
    case (state_q)
      ST_BUSY: begin
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        s_sel_o = g_sel;
        s_cti_o = g_cti;
        s_bte_o = g_bte;
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = g_we;
        m_dat_o = s_dat_i;
        m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
        m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
        m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
      end
      ST_TOERR: begin
        // Strobe withdrawn but cycle kept so the slave sees a clean abort; late acks dropped.
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        s_sel_o = g_sel;
        s_cti_o = g_cti;
        s_bte_o = g_bte;
        s_cyc_o = 1'b1;
        s_we_o  = g_we;
        m_err_o = grant_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (|m_cyc_i) begin
            grant_q <= arb_gnt;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= gidx;
            cnt_q   <= '0;
          end else if ((TIMEOUT > 0) && g_stb && !resp && (cnt_q == TO_LAST)) begin
            state_q <= ST_TOERR;
            cnt_q   <= '0;
          end else if ((TIMEOUT > 0) && g_stb && !resp) begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_TOERR: begin
          cnt_q <= '0;
          if (g_cyc) begin
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= gidx;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_na_conf_wb_arbiter.sv
// Directed bench for na_conf_wb_arbiter: reset, arbitration order, bursts, timeout, reset abort, read data.
module tb_na_conf_wb_arbiter;

  localparam int unsigned N = 2;

  logic          clk;
  logic          rst;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [4*N-1:0]  m_sel_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [3*N-1:0]  m_cti_i;
  logic [2*N-1:0]  m_bte_i;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o, m_rty_o, m_err_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [31:0]     s_dat_i;
  logic            s_ack_i, s_rty_i, s_err_i;
  logic [N-1:0]    grant_o;

  int checks = 0;
  int errors = 0;

  na_conf_wb_arbiter #(
    .NUM_MASTERS (N),
    .TIMEOUT     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_cti_i (m_cti_i),
    .m_bte_i (m_bte_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_rty_o (m_rty_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_cti_o (s_cti_o),
    .s_bte_o (s_bte_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_rty_i (s_rty_i),
    .s_err_i (s_err_i),
    .grant_o (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_adr_i[k*32 +: 32] = adr;
    m_dat_i[k*32 +: 32] = dat;
    m_sel_i[k*4 +: 4]   = 4'hF;
    m_cti_i[k*3 +: 3]   = cti;
    m_bte_i[k*2 +: 2]   = 2'b00;
  endtask

  task automatic clear_all();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_rty_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    rst = 1'b0;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc_o); end
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    checks++;
    if ({m_ack_o, m_rty_o, m_err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_resp: got %b want 000000", {m_ack_o, m_rty_o, m_err_o});
    end
    checks++;
    if (m_dat_o !== 32'h0) begin errors++; $display("FAIL reset_m_dat: got %h want 0", m_dat_o); end
    m_cyc_i = '0;
    m_stb_i = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_both_request();
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 3'b000);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h2222_2222, 3'b000);
    @(negedge clk);
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL arb_latency: s_cyc got %b want 0", s_cyc_o); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL both_grant_m0: got %b want 01", grant_o); end
    checks++;
    if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL both_s_cyc: got %b want 1", s_cyc_o); end
    checks++;
    if (s_adr_o !== 32'h0000_0010) begin errors++; $display("FAIL both_s_adr: got %h want 00000010", s_adr_o); end
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 2'b01) begin errors++; $display("FAIL both_ack_m0: got %b want 01", m_ack_o); end
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL release_idle: got %b want 00", grant_o); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b10) begin errors++; $display("FAIL both_grant_m1: got %b want 10", grant_o); end
    checks++;
    if (s_adr_o !== 32'h0000_0020) begin errors++; $display("FAIL m1_s_adr: got %h want 00000020", s_adr_o); end
    @(posedge clk); #1;
    clear_all();
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0000, 3'b010);
    @(posedge clk); #1;
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h5A5A_0000, 3'b000);
    for (int b = 0; b < 4; b++) begin
      cti = (b == 3) ? 3'b111 : 3'b010;
      set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100 + 32'(b * 4), 32'hA5A5_0000 + 32'(b), cti);
      @(negedge clk);
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_grant beat %0d: got %b want 10", b, grant_o); end
      checks++;
      if (m_ack_o !== 2'b10) begin errors++; $display("FAIL burst_ack beat %0d: got %b want 10", b, m_ack_o); end
      checks++;
      if (s_cti_o !== cti) begin errors++; $display("FAIL burst_cti beat %0d: got %b want %b", b, s_cti_o, cti); end
      @(posedge clk); #1;
    end
    s_ack_i = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b00 || m_ack_o !== 2'b00) begin
      errors++; $display("FAIL burst_release: grant %b ack %b want 00 00", grant_o, m_ack_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL burst_then_m0: got %b want 01", grant_o); end
    @(posedge clk); #1;
    clear_all();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b000);
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (m_err_o !== 2'b00 || s_stb_o !== 1'b1) begin
        errors++; $display("FAIL to_wait cycle %0d: err %b stb %b want 00 1", c, m_err_o, s_stb_o);
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (m_err_o !== 2'b01) begin errors++; $display("FAIL to_err: got %b want 01", m_err_o); end
    checks++;
    if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b1) begin
      errors++; $display("FAIL to_stb_cyc: stb %b cyc %b want 0 1", s_stb_o, s_cyc_o);
    end
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 2'b00) begin errors++; $display("FAIL to_late_ack: got %b want 00", m_ack_o); end
    s_ack_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 8) s_ack_i = 1'b1;
      #1;
      checks++;
      if (m_err_o !== 2'b00) begin errors++; $display("FAIL to_no_err cycle %0d: got %b want 00", c, m_err_o); end
      if (c == 8) begin
        checks++;
        if (m_ack_o !== 2'b01) begin errors++; $display("FAIL to_ack_wins: got %b want 01", m_ack_o); end
      end
    end
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (m_err_o !== 2'b00 || s_stb_o !== 1'b1) begin
      errors++; $display("FAIL to_after_ack: err %b stb %b want 00 1", m_err_o, s_stb_o);
    end
    @(posedge clk); #1;
    clear_all();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_0000, 3'b010);
    @(posedge clk);
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 2'b01) begin errors++; $display("FAIL mid_first_ack: got %b want 01", m_ack_o); end
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    rst = 1'b0;
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
      errors++; $display("FAIL mid_reset_abort: cyc %b grant %b want 0 00", s_cyc_o, grant_o);
    end
    checks++;
    if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
      errors++; $display("FAIL mid_reset_resp: ack %b err %b want 00 00", m_ack_o, m_err_o);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL mid_reset_prio: got %b want 01", grant_o); end
    @(posedge clk); #1;
    clear_all();
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 3'b000);
    @(posedge clk);
    @(negedge clk);
    s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", m_dat_o); end
    checks++;
    if (m_ack_o !== 2'b10) begin errors++; $display("FAIL read_ack: got %b want 10", m_ack_o); end
    checks++;
    if (s_adr_o !== 32'h0000_0004 || s_we_o !== 1'b0) begin
      errors++; $display("FAIL read_req: adr %h we %b want 00000004 0", s_adr_o, s_we_o);
    end
    @(posedge clk); #1;
    clear_all();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_all();
    @(posedge clk); #1;
    test_reset();
    test_both_request();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
